// File: rtl/spis_intf.sv
// SPI slave front-end: cmd/data deserialise to write buffer, prefetch+serialise read data on miso; optional SPIS_INTF_DBG_EN adds dbg_bus.
// Latency: wr_en one sclk after last data bit, read data one turnaround word after cmd; no backpressure, fully paced by master sclk.
module spis_intf #(
  parameter int S_FIFO_DEPTH = 512,
  parameter int BRST_WIDTH   = 14,
  localparam int AW          = $clog2(S_FIFO_DEPTH)
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [31:0]           wr_data,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [31:0]           rd_data,
  output logic                  cmd_rdnwr,
  output logic [BRST_WIDTH-1:0] cmd_brstlen,
  output logic [15:0]           cmd_addr,
  output logic                  spi_active,
  output logic                  frame_err
`ifdef SPIS_INTF_DBG_EN
  ,output logic [31:0]          dbg_bus
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RDUMMY = 3'd3,
    RDATA  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [4:0]            bit_cnt;
  logic [BRST_WIDTH-1:0] word_cnt;
  logic [31:0]           shift_q;
  logic [31:0]           prefetch_q;
  logic                  rd_pend_q;
  logic [31:0]           shift_in;
  logic                  bit_last;
  logic                  word_last;

  assign shift_in  = {shift_q[30:0], mosi};
  assign bit_last  = (bit_cnt == 5'd31);
  assign word_last = (word_cnt == cmd_brstlen);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ss_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CMD;
        CMD:     if (bit_last) state_nxt = shift_in[31] ? RDUMMY : WDATA;
        WDATA:   if (bit_last && word_last) state_nxt = DONE;
        RDUMMY:  if (bit_last) state_nxt = RDATA;
        RDATA:   if (bit_last && word_last) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Read strobes are decoded straight from state so a reset or abort kills them at once.
  always_comb begin
    miso_oe    = (state == RDUMMY) || (state == RDATA);
    miso       = (state == RDATA) && shift_q[31];
    spi_active = (state != IDLE);
    rd_en      = ((state == RDUMMY) && (bit_cnt == 5'd0)) ||
                 ((state == RDATA) && (bit_cnt == 5'd0) && (word_cnt < cmd_brstlen));
    rd_addr    = AW'(cmd_addr);
    if (state == RDATA) rd_addr = AW'(cmd_addr) + AW'(word_cnt) + AW'(1);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shift_q     <= '0;
      prefetch_q  <= '0;
      rd_pend_q   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cmd_rdnwr   <= 1'b0;
      cmd_brstlen <= '0;
      cmd_addr    <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      rd_pend_q <= rd_en;
      if (rd_pend_q) prefetch_q <= rd_data;
      if (ss_n) begin
        bit_cnt   <= '0;
        shift_q   <= '0;
        rd_pend_q <= 1'b0;
        frame_err <= (state != IDLE) && (state != DONE);
      end else begin
        case (state)
          IDLE: begin
            shift_q <= {31'b0, mosi};
            bit_cnt <= 5'd1;
          end
          CMD: begin
            shift_q <= shift_in;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_last) begin
              cmd_rdnwr   <= shift_in[31];
              cmd_brstlen <= shift_in[17 +: BRST_WIDTH];
              cmd_addr    <= shift_in[15:0];
              word_cnt    <= '0;
            end
          end
          WDATA: begin
            shift_q <= shift_in;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_last) begin
              wr_en    <= 1'b1;
              wr_data  <= shift_in;
              wr_addr  <= AW'(cmd_addr) + AW'(word_cnt);
              word_cnt <= word_cnt + BRST_WIDTH'(1);
            end
          end
          RDUMMY: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_last) shift_q <= prefetch_q;
          end
          RDATA: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_last) begin
              shift_q  <= prefetch_q;
              word_cnt <= word_cnt + BRST_WIDTH'(1);
            end else begin
              shift_q <= {shift_q[30:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPIS_INTF_DBG_EN
  // Snapshot of the previous cycle's state, so it trails the live counters by one sclk.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) dbg_bus <= '0;
    else        dbg_bus <= {state, 3'b0, bit_cnt, 1'b0, cmd_rdnwr, 5'b0, 14'(word_cnt)};
  end
`endif

endmodule

// File: tb/tb_spis_intf.sv
// Directed bench for spis_intf: frame-level model of expected strobes/miso per sclk edge plus literal end-of-frame checks.
module tb_spis_intf;
  localparam int AW = 9;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oe, wr_en, rd_en, cmd_rdnwr, spi_active, frame_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data = '0;
  logic [13:0]   cmd_brstlen;
  logic [15:0]   cmd_addr;
`ifdef SPIS_INTF_DBG_EN
  logic [31:0]   dbg_bus;
`endif

  spis_intf dut (
    .sclk(sclk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .cmd_rdnwr(cmd_rdnwr), .cmd_brstlen(cmd_brstlen), .cmd_addr(cmd_addr),
    .spi_active(spi_active), .frame_err(frame_err)
`ifdef SPIS_INTF_DBG_EN
    ,.dbg_bus(dbg_bus)
`endif
  );

  always #5 sclk = ~sclk;

  // Read buffer: data valid the cycle after rd_en.
  logic [31:0] rdbuf [0:511];
  always @(posedge sclk) if (rd_en) rd_data <= rdbuf[rd_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Model state for the current frame.
  bit          f_rd;
  int          f_B, f_A;
  logic [31:0] wdat [0:3];

  logic        chk_en = 1'b0;
  logic        exp_wr_en, exp_rd_en, exp_miso, exp_miso_oe, exp_spi_active, exp_frame_err;
  logic        exp_cmd_vld, exp_dbg_vld;
  logic [8:0]  exp_wr_addr, exp_rd_addr;
  logic [31:0] exp_wr_data;

  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [8:0]  rd_addr_q[$];
  logic        miso_q[$];
  int          ferr_n;

  task automatic set_exp_idle(input bit err);
    exp_wr_en = 0; exp_rd_en = 0; exp_miso = 0; exp_miso_oe = 0; exp_spi_active = 0;
    exp_frame_err = err; exp_cmd_vld = 0; exp_dbg_vld = 0;
    exp_wr_addr = '0; exp_rd_addr = '0; exp_wr_data = '0;
  endtask

  // Expected outputs in the cycle after in-frame edge e (edge 0 = first ss_n=0 edge).
  task automatic set_exp_frame(input int e);
    int k, j;
    set_exp_idle(0);
    exp_spi_active = 1;
    exp_cmd_vld = (e >= 31);
    exp_dbg_vld = (e == 10);
    if (!f_rd) begin
      if (e >= 63 && (e - 63) % 32 == 0 && (e - 63) / 32 <= f_B) begin
        k = (e - 63) / 32;
        exp_wr_en = 1;
        exp_wr_addr = 9'((f_A + k) % 512);
        exp_wr_data = wdat[2'(k)];
      end
    end else begin
      if (e >= 31 && e < 95 + 32 * f_B) exp_miso_oe = 1;
      if (e == 31) begin
        exp_rd_en = 1;
        exp_rd_addr = 9'(f_A % 512);
      end
      if (e >= 63 && e < 95 + 32 * f_B) begin
        k = (e - 63) / 32;
        j = (e - 63) % 32;
        exp_miso = rdbuf[9'((f_A + k) % 512)][5'(31 - j)];
        if (j == 0 && k < f_B) begin
          exp_rd_en = 1;
          exp_rd_addr = 9'((f_A + k + 1) % 512);
        end
      end
    end
  endtask

  // Single compare process: outputs checked against the model away from the active edge.
  always @(negedge sclk) begin
    if (chk_en) begin
      chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
      if (exp_wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        chk("wr_data", wr_data, exp_wr_data);
      end
      chk("rd_en", 32'(rd_en), 32'(exp_rd_en));
      if (exp_rd_en) chk("rd_addr", 32'(rd_addr), 32'(exp_rd_addr));
      chk("miso", 32'(miso), 32'(exp_miso));
      chk("miso_oe", 32'(miso_oe), 32'(exp_miso_oe));
      chk("spi_active", 32'(spi_active), 32'(exp_spi_active));
      chk("frame_err", 32'(frame_err), 32'(exp_frame_err));
      if (exp_cmd_vld) begin
        chk("cmd_rdnwr", 32'(cmd_rdnwr), 32'(f_rd));
        chk("cmd_brstlen", 32'(cmd_brstlen), 32'(f_B));
        chk("cmd_addr", 32'(cmd_addr), 32'(f_A));
      end
`ifdef SPIS_INTF_DBG_EN
      if (exp_dbg_vld) begin
        chk("dbg_state", 32'(dbg_bus[31:29]), 32'd1);
        chk("dbg_bit_cnt", 32'(dbg_bus[25:21]), 32'd10);
      end
`endif
      if (wr_en) begin
        wr_addr_q.push_back(wr_addr);
        wr_data_q.push_back(wr_data);
      end
      if (rd_en) rd_addr_q.push_back(rd_addr);
      if (miso_oe) miso_q.push_back(miso);
      if (frame_err) ferr_n++;
    end
  end

  task automatic step(input logic s, input logic m);
    @(negedge sclk);
    ss_n = s;
    mosi = m;
    @(posedge sclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    chk({tag, "_cmd_rdnwr"}, 32'(cmd_rdnwr), 32'd0);
    chk({tag, "_cmd_brstlen"}, 32'(cmd_brstlen), 32'd0);
    chk({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
    chk({tag, "_spi_active"}, 32'(spi_active), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // stop_at < 0: full frame plus two DONE edges; else ss_n rises (or reset hits) at that edge.
  task automatic run_frame(input bit rd, input int B, input int A, input int stop_at, input bit rst_stop);
    logic [31:0] cmd;
    int nd, last;
    logic m;
    cmd = {rd, 14'(B), 1'b0, 16'(A)};
    f_rd = rd; f_B = B; f_A = A;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); miso_q.delete(); ferr_n = 0;
    nd = rd ? 96 + 32 * B : 64 + 32 * B;
    last = (stop_at >= 0) ? stop_at : nd + 2;
    for (int e = 0; e < last; e++) begin
      if (e < 32) m = cmd[5'(31 - e)];
      else if (!rd && e < nd) m = wdat[2'((e - 32) / 32)][5'(31 - (e - 32) % 32)];
      else m = 1'b1;
      step(1'b0, m);
      set_exp_frame(e);
    end
    if (rst_stop) begin
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      chk_en = 1'b0;
      @(negedge sclk);
      ss_n = 1'b1;
      rst_n = 1'b1;
      step(1'b1, 1'b0);
      set_exp_idle(0);
      chk_en = 1'b1;
      step(1'b1, 1'b0);
      set_exp_idle(0);
    end else begin
      step(1'b1, 1'b0);
      set_exp_idle(last < nd);
      step(1'b1, 1'b0);
      set_exp_idle(0);
    end
  endtask

  function automatic logic [31:0] miso_word(input int w);
    logic [31:0] v = '0;
    for (int b = 0; b < 32; b++) v = {v[30:0], miso_q[32 * w + b]};
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) rdbuf[i] = 32'h5A000000 ^ (32'(i) * 32'h00010203);
    rdbuf[9'h100] = 32'h11111111;
    rdbuf[9'h101] = 32'h22222222;
    rdbuf[9'h102] = 32'h33333333;
    set_exp_idle(0);
    #1;
    check_all_zero("reset");
    #20;
    @(negedge sclk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Single-word write
    wdat[0] = 32'hA5A55A5A;
    run_frame(0, 0, 'h10, -1, 0);
    chk("w1_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("w1_addr", 32'(wr_addr_q[0]), 32'h010);
      chk("w1_data", wr_data_q[0], 32'hA5A55A5A);
    end
    chk("w1_rd_count", 32'(rd_addr_q.size()), 32'd0);

    // Three-word read, cmd 0x8004_0100
    run_frame(1, 2, 'h100, -1, 0);
    chk("r3_bits", 32'(miso_q.size()), 32'd128);
    if (miso_q.size() >= 128) begin
      chk("r3_dummy", miso_word(0), 32'h00000000);
      chk("r3_word0", miso_word(1), 32'h11111111);
      chk("r3_word1", miso_word(2), 32'h22222222);
      chk("r3_word2", miso_word(3), 32'h33333333);
    end
    chk("r3_rd_count", 32'(rd_addr_q.size()), 32'd3);
    if (rd_addr_q.size() >= 3) begin
      chk("r3_rd_addr0", 32'(rd_addr_q[0]), 32'h100);
      chk("r3_rd_addr1", 32'(rd_addr_q[1]), 32'h101);
      chk("r3_rd_addr2", 32'(rd_addr_q[2]), 32'h102);
    end

    // Address wrap
    wdat[0] = 32'h00000001; wdat[1] = 32'h80000002; wdat[2] = 32'hFFFF0003;
    run_frame(0, 2, 'h1FF, -1, 0);
    chk("wrap_count", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() >= 3) begin
      chk("wrap_addr0", 32'(wr_addr_q[0]), 32'h1FF);
      chk("wrap_addr1", 32'(wr_addr_q[1]), 32'h000);
      chk("wrap_addr2", 32'(wr_addr_q[2]), 32'h001);
    end

    // Abort after 20 bits of word 1 in a two-word write
    wdat[0] = 32'hCAFE0001; wdat[1] = 32'hCAFE0002;
    run_frame(0, 1, 'h20, 84, 0);
    chk("abort_wr_count", 32'(wr_addr_q.size()), 32'd1);
    chk("abort_ferr_count", 32'(ferr_n), 32'd1);

    // Reset mid-RDATA, then a clean write
    run_frame(1, 2, 'h100, 75, 1);
    wdat[0] = 32'hDEADBEEF;
    run_frame(0, 0, 'h5, -1, 0);
    chk("post_rst_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("post_rst_addr", 32'(wr_addr_q[0]), 32'h005);
      chk("post_rst_data", wr_data_q[0], 32'hDEADBEEF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spis_intf.md
Name: spis_intf

Overview:
- SPI slave serial front-end, counterpart of the SPI master interface; sits at the slave end of the 4-wire link (one instance per ss_n line).
- Deserialises the 32-bit command word and write data from mosi into the slave write buffer.
- Prefetches from the slave read buffer and serialises read data onto miso.
- All logic is clocked by the master-supplied sclk.

Parameters:
- S_FIFO_DEPTH, 512, slave buffer depth in 32-bit words (power of 2); AW = $clog2(S_FIFO_DEPTH).
- BRST_WIDTH, 14, width of the burst-length field.

Ports:
- sclk  in  1  SPI clock from master; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ss_n  in  1  slave select, active low, sampled on sclk.
- mosi  in  1  serial data from master, MSB first.
- miso  out  1  serial data to master; master captures it on the sclk falling edge.
- miso_oe  out  1  miso output enable for the board-level shared line.
- wr_en  out  1  one-cycle write strobe to the write buffer.
- wr_addr  out  AW  write buffer address.
- wr_data  out  32  write buffer data.
- rd_en  out  1  one-cycle read strobe to the read buffer.
- rd_addr  out  AW  read buffer address.
- rd_data  in  32  read buffer data, valid the cycle after rd_en.
- cmd_rdnwr  out  1  latched command direction: 1 = read.
- cmd_brstlen  out  BRST_WIDTH  latched burst length, encoded as words - 1.
- cmd_addr  out  16  latched start address.
- spi_active  out  1  frame in progress.
- frame_err  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Reset: state IDLE; all outputs 0; bit_cnt, word_cnt and shift registers cleared. Reset takes effect immediately, including mid-frame.
- Command word (MSB first):
  - [31] rdnwr
  - [30:17] brstlen
  - [16] reserved, ignored
  - [15:0] addr
- Counters: bit_cnt is 5 bits and wraps 31 -> 0. word_cnt is BRST_WIDTH bits and counts completed data words.
- IDLE -> CMD: on the first edge with ss_n = 0, mosi is captured as cmd bit 31 and spi_active goes to 1.
- CMD: shift mosi in on each edge. At bit_cnt = 31, register cmd_* (visible the next cycle), clear word_cnt, then go to WDATA (rdnwr = 0) or RDUMMY (rdnwr = 1).
- WDATA:
  - Shift mosi in.
  - At bit_cnt = 31: the next cycle has wr_en = 1, wr_data = the full word, wr_addr = (cmd_addr + word_cnt) mod S_FIFO_DEPTH; word_cnt increments.
  - After word brstlen is written, go to DONE.
- RDUMMY:
  - One 32-bit turnaround word; miso = 0, miso_oe = 1.
  - rd_en pulses on the first cycle in RDUMMY with rd_addr = cmd_addr[AW-1:0].
  - rd_data is captured into the prefetch register one cycle later.
  - At bit_cnt = 31, the shift register loads from the prefetch register; go to RDATA.
- RDATA:
  - miso = shift[31]; shift left on each edge.
  - At bit_cnt = 0 of word k with k < brstlen: rd_en pulses with rd_addr = (cmd_addr + k + 1) mod S_FIFO_DEPTH; the prefetch register captures rd_data the next cycle.
  - At bit_cnt = 31: reload the shift register from the prefetch register and increment word_cnt. After word brstlen, go to DONE.
- DONE: ignore mosi; miso = 0; miso_oe = 0; no strobes; hold until ss_n = 1.
- ss_n = 1 sampled in any state returns to IDLE on that edge; spi_active = 0 and miso_oe = 0.
- Abort: if ss_n = 1 is sampled in CMD, WDATA, RDUMMY or RDATA, frame_err pulses for 1 cycle. A partial write word is discarded (no wr_en). A pending prefetch is dropped.
- The master provides at least 2 sclk edges with ss_n = 1 between frames.
- Address wrap: only the low AW bits are used; address S_FIFO_DEPTH-1 is followed by 0.
- brstlen = 0 means a single word. brstlen = 2^BRST_WIDTH - 1 gives 16384 words; word_cnt must not overflow before DONE.
- Same-edge events: wr_en and frame_err never coincide (a completed word is written before any abort).

Optional Feature:
- Macro SPIS_INTF_DBG_EN.
- When defined: adds port dbg_bus, out, 32 bits, = {state[2:0], 3'b0, bit_cnt[4:0], 1'b0, cmd_rdnwr, 5'b0, word_cnt[13:0]}, registered, reset 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Write of 1 word: cmd 0x0000_0010 then data 0xA5A5_5A5A -> one wr_en pulse with wr_addr = 0x010, wr_data = 0xA5A5_5A5A; state DONE; no rd_en.
- Read of 3 words: cmd 0x8004_0100, buffer[0x100..0x102] = 0x11111111/0x22222222/0x33333333 -> 32 zero bits then those three words on miso MSB first; exactly 3 rd_en pulses at addr 0x100, 0x101, 0x102; miso_oe = 0 after DONE.
- Wrap: write cmd brstlen = 2, addr 0x01FF -> wr_addr sequence 0x1FF, 0x000, 0x001.
- Abort: ss_n rises after 20 bits of write word 1 (burst of 2) -> wr_en for word 0 only, frame_err = 1 for 1 cycle, IDLE, spi_active = 0.
- Reset mid-read: rst_n low during RDATA -> all outputs 0 immediately; next frame with cmd 0x0000_0005 + data 0xDEADBEEF writes addr 0x005 correctly.
- With SPIS_INTF_DBG_EN: mid-CMD at bit_cnt = 10 -> dbg_bus[31:29] = CMD encoding, dbg_bus[25:21] = 10.
